// File: rtl/scan_chain_loader_if.sv
// Bitstream word stream into the scan-chain loader: valid/ready handshake
// with a WORD_W-bit payload. The master is the bitstream source.
interface scan_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/scan_chain_loader.sv
// Serialises a bitstream word stream LSB-first onto the LUT configuration scan
// chain, generating sc_clk from clk with a CLK_DIV-cycle half-period.
module scan_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 8,
    parameter int CLK_DIV   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    scan_chain_loader_if.slave             word_if,
    output logic                           sc_clk,
    output logic                           sc_data,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sc_data_d;
    logic              word_ready_q;
    logic              phase_end;

    assign phase_end          = (div_q == LAST_DIV);
    assign word_if.word_ready = word_ready_q;
    assign bit_count          = cnt_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        sc_data_d = sc_data;

        // abort outranks everything, including a handshake in the same cycle
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                    end
                end
                S_FETCH: begin
                    if (word_if.word_valid && word_ready_q) begin
                        shreg_d   = word_if.word_data;
                        sc_data_d = word_if.word_data[0];
                        idx_d     = '0;
                        div_d     = '0;
                        state_d   = S_LOW;
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        div_d   = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_HIGH;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (phase_end) begin
                        div_d = '0;
                        if (cnt_q == LAST_BIT) begin
                            state_d = S_DONE;
                        end else if (idx_q == LAST_IDX) begin
                            state_d = S_FETCH;
                        end else begin
                            shreg_d   = shreg_q >> 1;
                            sc_data_d = shreg_d[0];
                            idx_d     = idx_q + IDX_W'(1);
                            state_d   = S_LOW;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered decodes of the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            sc_clk       <= 1'b0;
            sc_data      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            word_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            sc_clk       <= (state_d == S_HIGH);
            sc_data      <= sc_data_d;
            busy         <= (state_d != S_IDLE);
            done         <= (state_d == S_DONE);
            word_ready_q <= (state_d == S_FETCH);
        end
    end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader: a 128-bit/8-bit/div-1 instance and a
// 10-bit/4-bit/div-3 instance, each with a scan-chain tail model.
module tb_scan_chain_loader;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance: 128 bits, 8-bit words, CLK_DIV=1
    logic       m_start = 1'b0;
    logic       m_abort = 1'b0;
    logic       m_sc_clk, m_sc_data, m_busy, m_done;
    logic [7:0] m_bit_count;
    scan_chain_loader_if #(.WORD_W(8)) m_if ();

    scan_chain_loader #(.CHAIN_LEN(128), .WORD_W(8), .CLK_DIV(1)) u_main (
        .clk       (clk),
        .reset     (reset),
        .start     (m_start),
        .abort     (m_abort),
        .word_if   (m_if),
        .sc_clk    (m_sc_clk),
        .sc_data   (m_sc_data),
        .busy      (m_busy),
        .done      (m_done),
        .bit_count (m_bit_count)
    );

    // ---------------- aux instance: 10 bits, 4-bit words, CLK_DIV=3
    logic       a_start = 1'b0;
    logic       a_abort = 1'b0;
    logic       a_sc_clk, a_sc_data, a_busy, a_done;
    logic [3:0] a_bit_count;
    scan_chain_loader_if #(.WORD_W(4)) a_if ();

    scan_chain_loader #(.CHAIN_LEN(10), .WORD_W(4), .CLK_DIV(3)) u_aux (
        .clk       (clk),
        .reset     (reset),
        .start     (a_start),
        .abort     (a_abort),
        .word_if   (a_if),
        .sc_clk    (a_sc_clk),
        .sc_data   (a_sc_data),
        .busy      (a_busy),
        .done      (a_done),
        .bit_count (a_bit_count)
    );

    logic [7:0] m_words [16] = '{8'hA5, 8'h3C, 8'h01, 8'hFE, 8'h96, 8'h7B, 8'h00, 8'hFF,
                                 8'h42, 8'hC3, 8'h18, 8'h6D, 8'hE7, 8'h2A, 8'h81, 8'h5F};
    logic [3:0] a_words [4]  = '{4'h5, 4'hA, 4'hF, 4'h3};
    int         exp_low [9]  = '{3, 3, 3, 4, 3, 3, 3, 4, 3};

    // ---------------- scan-chain tail models (sampled on the falling clk edge)
    logic         m_clr = 1'b0;
    int           m_edges, m_dones;
    logic         m_prev_clk;
    logic [127:0] m_lut;

    always @(negedge clk) begin
        if (m_clr) begin
            m_edges = 0; m_dones = 0; m_lut = '0; m_prev_clk = m_sc_clk;
        end else begin
            if (m_sc_clk === 1'b1 && m_prev_clk === 1'b0) begin
                m_edges++;
                m_lut = {m_sc_data, m_lut[127:1]};
            end
            if (m_done === 1'b1) m_dones++;
            m_prev_clk = m_sc_clk;
        end
    end

    logic        a_clr = 1'b0;
    int          a_edges, a_dones, a_viol, a_run;
    logic        a_prev_clk, a_prev_data;
    logic [15:0] a_cap;
    int          a_low[$];
    int          a_high[$];

    always @(negedge clk) begin
        if (a_clr) begin
            a_edges = 0; a_dones = 0; a_viol = 0; a_run = 0; a_cap = '0;
            a_low.delete(); a_high.delete();
            a_prev_clk = a_sc_clk; a_prev_data = a_sc_data;
        end else begin
            if (a_sc_clk !== a_prev_clk) begin
                if (a_prev_clk === 1'b1) a_high.push_back(a_run);
                else a_low.push_back(a_run);
                a_run = 1;
                if (a_sc_clk === 1'b1) begin
                    if (a_edges < 16) a_cap[a_edges] = a_sc_data;
                    a_edges++;
                end
            end else begin
                a_run++;
            end
            if (a_sc_clk === 1'b1 && a_sc_data !== a_prev_data) a_viol++;
            if (a_done === 1'b1) a_dones++;
            a_prev_clk = a_sc_clk;
            a_prev_data = a_sc_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        m_clr = 1'b1; a_clr = 1'b1;
        @(negedge clk);
        #1;
        m_clr = 1'b0; a_clr = 1'b0;
        tick;
    endtask

    function automatic int lut_errors();
        int n = 0;
        for (int s = 0; s < 128; s++)
            if (m_lut[s] !== m_words[s / 8][s % 8]) n++;
        return n;
    endfunction

    // Streams m_words into the main loader until done; optional stall, abort, start pokes.
    task automatic feed_main(input int stall_word, input int stall_len, input int abort_at,
                             input bit poke_start, output int accepted, output int stall_bad,
                             output int nonmono, output int gap, output bit aborted,
                             output bit timed_out);
        int idx = 0, stall = 0, guard = 0, acc_c = -1, rise_c = -1;
        bit go, stalling;
        logic [7:0] prev_cnt;
        accepted = 0; stall_bad = 0; nonmono = 0; gap = -1; aborted = 0; timed_out = 0;
        prev_cnt = m_bit_count;
        while (m_done !== 1'b1 && !timed_out) begin
            if (abort_at > 0 && m_bit_count == 8'(abort_at)) begin
                m_abort = 1'b1; m_if.word_valid = 1'b0;
                tick;
                m_abort = 1'b0; aborted = 1;
                return;
            end
            stalling = (idx == stall_word) && (stall < stall_len);
            m_if.word_valid = (idx < 16) && !stalling;
            m_if.word_data  = m_words[idx % 16];
            if (stalling && m_if.word_ready === 1'b1) begin
                stall++;
                if (m_sc_clk !== 1'b0 || m_bit_count !== 8'(stall_word * 8)) stall_bad++;
            end else if (stalling && stall > 0) begin
                stall_bad++;
            end
            m_start = poke_start && (m_busy === 1'b1) && (guard % 7 == 3);
            go = m_if.word_valid && (m_if.word_ready === 1'b1);
            if (go && acc_c < 0) acc_c = guard;
            tick;
            guard++;
            if (go) begin idx++; accepted++; end
            if (m_sc_clk === 1'b1 && rise_c < 0) rise_c = guard;
            if (m_bit_count < prev_cnt) nonmono++;
            prev_cnt = m_bit_count;
            if (guard >= 3000) timed_out = 1;
        end
        m_if.word_valid = 1'b0;
        m_start = 1'b0;
        gap = rise_c - acc_c;
    endtask

    task automatic feed_aux(output int accepted, output int gap, output bit timed_out);
        int idx = 0, guard = 0, acc_c = -1, rise_c = -1;
        bit go;
        accepted = 0; timed_out = 0;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        while (a_done !== 1'b1 && !timed_out) begin
            a_if.word_valid = 1'b1;
            a_if.word_data  = a_words[idx % 4];
            go = (a_if.word_ready === 1'b1);
            if (go && acc_c < 0) acc_c = guard;
            tick;
            guard++;
            if (go) begin idx++; accepted++; end
            if (a_sc_clk === 1'b1 && rise_c < 0) rise_c = guard;
            if (guard >= 1000) timed_out = 1;
        end
        a_if.word_valid = 1'b0;
        gap = rise_c - acc_c;
    endtask

    task automatic test_reset;
        m_if.word_valid = 1'b0; m_if.word_data = '0;
        a_if.word_valid = 1'b0; a_if.word_data = '0;
        reset = 1'b1;
        repeat (3) tick;
        checks++;
        if ({m_sc_clk, m_sc_data, m_busy, m_done, m_if.word_ready, m_bit_count} !== 13'd0) begin
            errors++;
            $display("FAIL reset_main got %b want 0",
                     {m_sc_clk, m_sc_data, m_busy, m_done, m_if.word_ready, m_bit_count});
        end
        checks++;
        if ({a_sc_clk, a_sc_data, a_busy, a_done, a_if.word_ready, a_bit_count} !== 9'd0) begin
            errors++;
            $display("FAIL reset_aux got %b want 0",
                     {a_sc_clk, a_sc_data, a_busy, a_done, a_if.word_ready, a_bit_count});
        end
        reset = 1'b0;
        tick;
        clear_mon;
    endtask

    task automatic test_idle_start_abort;
        m_start = 1'b1; m_abort = 1'b1;
        tick;
        m_start = 1'b0; m_abort = 1'b0;
        tick;
        checks++;
        if ({m_busy, m_if.word_ready} !== 2'b00) begin
            errors++;
            $display("FAIL idle_start_abort busy/ready got %b want 00", {m_busy, m_if.word_ready});
        end
    endtask

    task automatic test_full_load;
        int acc, sb, nm, gap; bit ab, to;
        clear_mon;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        checks++;
        if ({m_busy, m_if.word_ready} !== 2'b11) begin
            errors++;
            $display("FAIL start_to_ready got %b want 11", {m_busy, m_if.word_ready});
        end
        feed_main(99, 0, 0, 1'b0, acc, sb, nm, gap, ab, to);
        checks++;
        if (to) begin errors++; $display("FAIL full_timeout got 1 want 0"); end
        checks++;
        if (gap != 2) begin errors++; $display("FAIL full_first_edge_gap got %0d want 2", gap); end
        tick;
        checks++;
        if ({m_done, m_busy, m_sc_clk} !== 3'b000) begin
            errors++;
            $display("FAIL full_post_done got %b want 000", {m_done, m_busy, m_sc_clk});
        end
        tick;
        checks++;
        if (m_edges != 128) begin errors++; $display("FAIL full_edges got %0d want 128", m_edges); end
        checks++;
        if (m_dones != 1) begin errors++; $display("FAIL full_done_pulses got %0d want 1", m_dones); end
        checks++;
        if (m_bit_count !== 8'd128) begin
            errors++; $display("FAIL full_bit_count got %0d want 128", m_bit_count);
        end
        checks++;
        if (acc != 16) begin errors++; $display("FAIL full_words got %0d want 16", acc); end
        checks++;
        if (lut_errors() != 0) begin
            errors++; $display("FAIL full_lut_content got %0d bad selects want 0", lut_errors());
        end
    endtask

    task automatic test_small_chain;
        int acc, gap; bit to;
        clear_mon;
        feed_aux(acc, gap, to);
        repeat (3) tick;
        checks++;
        if (to) begin errors++; $display("FAIL small_timeout got 1 want 0"); end
        checks++;
        if (a_edges != 10) begin errors++; $display("FAIL small_edges got %0d want 10", a_edges); end
        checks++;
        if (a_cap !== 16'h03A5) begin
            errors++; $display("FAIL small_bits got %h want 03a5", a_cap);
        end
        checks++;
        if (acc != 3) begin errors++; $display("FAIL small_words got %0d want 3", acc); end
        checks++;
        if ({a_bit_count, a_dones == 1} !== 5'b1010_1) begin
            errors++; $display("FAIL small_count_done got %0d/%0d want 10/1", a_bit_count, a_dones);
        end
    endtask

    task automatic test_clk_div;
        int acc, gap, bad_hi, bad_lo; bit to;
        clear_mon;
        feed_aux(acc, gap, to);
        repeat (3) tick;
        bad_hi = 0; bad_lo = 0;
        foreach (a_high[i]) if (a_high[i] != 3) bad_hi++;
        if (a_low.size() != 10) bad_lo = 100;
        else for (int i = 0; i < 9; i++) if (a_low[i + 1] != exp_low[i]) bad_lo++;
        checks++;
        if (gap != 4) begin errors++; $display("FAIL div_first_edge_gap got %0d want 4", gap); end
        checks++;
        if (a_high.size() != 10 || bad_hi != 0) begin
            errors++; $display("FAIL div_high_phase got %0d runs, %0d bad want 10, 0", a_high.size(), bad_hi);
        end
        checks++;
        if (bad_lo != 0) begin errors++; $display("FAIL div_low_phase got %0d bad want 0", bad_lo); end
        checks++;
        if (a_viol != 0) begin errors++; $display("FAIL div_data_hold got %0d changes want 0", a_viol); end
    endtask

    task automatic test_backpressure;
        int acc, sb, nm, gap; bit ab, to;
        clear_mon;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        feed_main(4, 20, 0, 1'b0, acc, sb, nm, gap, ab, to);
        repeat (2) tick;
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
        checks++;
        if (sb != 0) begin errors++; $display("FAIL bp_stall_state got %0d bad cycles want 0", sb); end
        checks++;
        if (m_edges != 128 || m_dones != 1) begin
            errors++; $display("FAIL bp_edges_done got %0d/%0d want 128/1", m_edges, m_dones);
        end
        checks++;
        if (lut_errors() != 0) begin
            errors++; $display("FAIL bp_lut_content got %0d bad selects want 0", lut_errors());
        end
    endtask

    task automatic test_abort;
        int acc, sb, nm, gap; bit ab, to;
        clear_mon;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        feed_main(99, 0, 37, 1'b0, acc, sb, nm, gap, ab, to);
        checks++;
        if (!ab) begin errors++; $display("FAIL abort_reached got 0 want 1"); end
        checks++;
        if ({m_busy, m_sc_clk, m_if.word_ready} !== 3'b000) begin
            errors++; $display("FAIL abort_idle got %b want 000", {m_busy, m_sc_clk, m_if.word_ready});
        end
        repeat (4) tick;
        checks++;
        if (m_dones != 0 || m_edges != 37) begin
            errors++; $display("FAIL abort_no_done got %0d dones %0d edges want 0, 37", m_dones, m_edges);
        end
        clear_mon;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        feed_main(99, 0, 0, 1'b0, acc, sb, nm, gap, ab, to);
        repeat (2) tick;
        checks++;
        if (to || m_edges != 128 || m_dones != 1 || lut_errors() != 0) begin
            errors++;
            $display("FAIL abort_reload got %0d edges %0d dones %0d bad want 128, 1, 0",
                     m_edges, m_dones, lut_errors());
        end
    endtask

    task automatic test_async_reset;
        int idx = 0, guard = 0;
        bit go;
        clear_mon;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        while (!(m_bit_count == 8'd20 && m_sc_clk === 1'b1) && guard < 500) begin
            m_if.word_valid = 1'b1;
            m_if.word_data  = m_words[idx % 16];
            go = (m_if.word_ready === 1'b1);
            tick;
            guard++;
            if (go) idx++;
        end
        checks++;
        if (guard >= 500) begin errors++; $display("FAIL arst_reach_high got timeout want bit 20 high"); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({m_sc_clk, m_busy, m_sc_data, m_if.word_ready, m_bit_count} !== 12'd0) begin
            errors++;
            $display("FAIL arst_immediate got %b want 0",
                     {m_sc_clk, m_busy, m_sc_data, m_if.word_ready, m_bit_count});
        end
        #1;
        reset = 1'b0;
        m_if.word_valid = 1'b0;
        repeat (3) tick;
        checks++;
        if ({m_busy, m_sc_clk} !== 2'b00) begin
            errors++; $display("FAIL arst_stays_idle got %b want 00", {m_busy, m_sc_clk});
        end
    endtask

    task automatic test_start_ignored;
        int acc, sb, nm, gap; bit ab, to;
        clear_mon;
        m_start = 1'b1;
        tick;
        m_start = 1'b0;
        feed_main(99, 0, 0, 1'b1, acc, sb, nm, gap, ab, to);
        repeat (2) tick;
        checks++;
        if (nm != 0) begin errors++; $display("FAIL busy_start_monotonic got %0d drops want 0", nm); end
        checks++;
        if (to || acc != 16 || m_edges != 128 || m_dones != 1) begin
            errors++;
            $display("FAIL busy_start_load got %0d words %0d edges %0d dones want 16, 128, 1",
                     acc, m_edges, m_dones);
        end
        checks++;
        if (lut_errors() != 0) begin
            errors++; $display("FAIL busy_start_lut got %0d bad selects want 0", lut_errors());
        end
    endtask

    initial begin
        test_reset;
        test_idle_start_abort;
        test_full_load;
        test_small_chain;
        test_clk_div;
        test_backpressure;
        test_abort;
        test_async_reset;
        test_start_ignored;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
- Drives the configuration scan chain of the LUT fabric (sc_clk / sc_data) from a parallel word stream, replacing bench-side bit-banging.
- Accepts bitstream words over a valid/ready handshake, serializes them LSB-first and generates sc_clk from the system clock.
- Sits between the bitstream source (host/ROM) and the head of the LUT scan chain.

Parameters:
- CHAIN_LEN, 128, total scan-chain bits to shift per load (>=1).
- WORD_W, 8, input word width in bits (>=1).
- CLK_DIV, 1, sc_clk half-period in clk cycles (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  cancel the load in progress.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts a word this cycle.
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- sc_clk  out  1  scan-chain clock; data captured on its rising edge.
- sc_data  out  1  scan-chain serial data.
- busy  out  1  load in progress (not IDLE).
- done  out  1  one-cycle pulse when the final bit's sc_clk high phase completes.
- bit_count  out  $clog2(CHAIN_LEN+1)  bits shifted (rising edges issued) in the current load.

Behaviour:
- Reset, asynchronous: immediately forces state IDLE, sc_clk=0, sc_data=0, word_ready=0, busy=0, done=0, bit_count=0. No clk edge is required.
- Bit ordering: chain bit i = word k, bit j, where i = k*WORD_W + j. Chain bit 0 is shifted first.
- Words fetched = ceil(CHAIN_LEN/WORD_W). Unused upper bits of the last word are never driven.
- All outputs are registered.
- States:
  - IDLE: busy=0, word_ready=0, sc_clk=0. On start -> FETCH; bit_count cleared to 0.
  - FETCH: word_ready=1, sc_clk=0, sc_data holds its last value. On word_valid&word_ready, load the shift register -> LOW. Otherwise wait indefinitely (backpressure stall).
  - LOW: sc_clk=0, sc_data=shreg[0], driven from the first LOW cycle. Stays CLK_DIV cycles -> HIGH.
  - HIGH: sc_clk=1, sc_data unchanged. bit_count increments on entry. Stays CLK_DIV cycles, then:
    - if the last chain bit was issued -> DONE;
    - else if the last bit of the word was issued -> FETCH;
    - else shift the register right -> LOW.
  - DONE: done=1 for exactly one cycle, sc_clk=0 -> IDLE. bit_count keeps CHAIN_LEN until the next start.
- Timing:
  - start high in cycle 0 -> word_ready=1 in cycle 1.
  - Word accepted in cycle t -> first bit on sc_data in cycle t+1; first sc_clk rise in cycle t+1+CLK_DIV.
  - Each bit costs 2*CLK_DIV cycles. Each word adds at least 1 FETCH cycle.
- sc_data changes only while sc_clk is low (setup and hold to the rising edge = CLK_DIV cycles each).
- Exactly CHAIN_LEN sc_clk rising edges per completed load. sc_clk is low in every non-HIGH state.
- start is ignored while busy.
- abort in any non-IDLE state -> IDLE on the next clk edge: sc_clk=0, word_ready=0, no done pulse. abort has priority over every other transition, including the word handshake in the same cycle.
- start and abort in the same IDLE cycle: abort wins, stay IDLE.

Test Plan:
1. CHAIN_LEN=128, WORD_W=8, CLK_DIV=1, chain tail driving an N=128 LUT; 16 random words, no stalls -> 128 rising edges, one done pulse, bit_count=128. LUT stored data equals the concatenated words. Every LUT select 0..127 reads the matching bit.
2. CHAIN_LEN=10, WORD_W=4, words 0x5, 0xA, 0xF -> exactly 10 edges sampling 1,0,1,0,0,1,0,1,1,1. Only 3 words accepted. Bits 2–3 of the third word are never driven.
3. Backpressure: word_valid held low for 20 cycles before word 5 -> sc_clk stays 0 with no edges, word_ready stays 1, bit_count stays 32. After the stall the stream resumes and the final content is correct.
4. CLK_DIV=3 -> sc_clk high 3 cycles / low 3 cycles. sc_data never changes in HIGH or on the cycle of a rising edge. First edge lands 4 cycles after word acceptance.
5. abort asserted after bit_count=37 -> next cycle busy=0, sc_clk=0, no done pulse. A following start performs a full 128-bit load with done.
6. Asynchronous reset asserted mid-HIGH, between clk edges -> sc_clk and busy drop immediately. start pulses while busy are ignored: no restart, and bit_count keeps counting up.
